// File: rtl/csa_accumulator.sv
// csa_accumulator
//   Carry-save accumulator. Operands are folded into a redundant (S, C) pair
//   with one full-adder level per operand, so frames can stream at one operand
//   per clock. When the last operand arrives, the carries are resolved CHUNK
//   bits per cycle over ACC_W/CHUNK cycles. The result is then held until the
//   consumer takes it.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   in_valid/ready  operand handshake (in_ready is high only while accumulating)
//   in_data         unsigned operand, zero-extended to ACC_W
//   in_sub          subtract this operand
//   in_last         final operand of the frame
//   clr             synchronous frame abort (effective while accumulating only)
//   out_valid/ready result handshake
//   out_data        frame result modulo 2^ACC_W
//   out_count       operands accepted in the frame, saturating at 65535
module csa_accumulator #(
  parameter int WIDTH = 64,
  parameter int ACC_W = 72,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [15:0]      out_count
);

  localparam int N     = ACC_W / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (ACC_W % CHUNK != 0) begin : g_bad_chunk
      $error("csa_accumulator: ACC_W must be a multiple of CHUNK");
    end
    if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
      $error("csa_accumulator: ACC_W must be at least WIDTH+1");
    end
  endgenerate

  typedef enum logic [1:0] {S_ACCUM, S_RESOLVE, S_OUTPUT} state_t;

  state_t             state;
  logic [ACC_W-1:0]   s_vec, c_vec, result, x;
  logic [ACC_W-2:0]   maj;   // top majority bit would shift out; never built
  logic [CHUNK:0]     csum;
  logic               cy;
  logic [IDX_W-1:0]   idx;
  logic [15:0]        count, count_inc;
  logic               accept;

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_OUTPUT);
  assign out_data  = result;
  assign out_count = count;
  assign accept    = in_valid && (state == S_ACCUM);
  assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

  always_comb begin
    // Subtraction is ~X plus a one injected at C[0]; the +1 costs nothing
    // because C[0] is always vacant after the shift.
    x = {{(ACC_W-WIDTH){1'b0}}, in_data};
    if (in_sub) x = ~x;
    maj  = (s_vec[ACC_W-2:0] & c_vec[ACC_W-2:0]) |
           (s_vec[ACC_W-2:0] & x[ACC_W-2:0]) |
           (c_vec[ACC_W-2:0] & x[ACC_W-2:0]);
    csum = {1'b0, s_vec[idx*CHUNK +: CHUNK]} + {1'b0, c_vec[idx*CHUNK +: CHUNK]}
         + {{CHUNK{1'b0}}, cy};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_ACCUM;
      s_vec  <= '0;
      c_vec  <= '0;
      result <= '0;
      count  <= '0;
      cy     <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (accept) begin
            if (clr) begin
              // clear and accept together: operand opens a fresh frame
              s_vec <= x;
              c_vec <= {{(ACC_W-1){1'b0}}, in_sub};
              count <= 16'd1;
            end else begin
              s_vec <= s_vec ^ c_vec ^ x;
              c_vec <= {maj, in_sub};
              count <= count_inc;
            end
            if (in_last) begin
              state <= S_RESOLVE;
              idx   <= '0;
              cy    <= 1'b0;
            end
          end else if (clr) begin
            s_vec <= '0;
            c_vec <= '0;
            count <= '0;
          end
        end
        S_RESOLVE: begin
          result[idx*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
          cy  <= csum[CHUNK];   // final chunk's carry-out is dropped (mod 2^ACC_W)
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(N-1)) state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            state <= S_ACCUM;
            s_vec <= '0;
            c_vec <= '0;
            count <= '0;
          end
        end
        default: state <= S_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
module tb_csa_accumulator;

  localparam int WIDTH = 8;
  localparam int ACC_W = 16;
  localparam int CHUNK = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_sub, in_last, clr;
  logic [WIDTH-1:0] in_data;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] out_data;
  logic [15:0]      out_count;

  typedef struct {
    logic [15:0] data;
    logic [15:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  // drive one operand; returns #1 after the accepting edge
  task automatic send(input logic [7:0] d, input bit sub, input bit last, input bit c);
    in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last; clr = c;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sub = 1'b0; in_last = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit to);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !out_valid;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // wait for a result, compare it against the scoreboard head, take it
  task automatic take_result(input string name);
    int lat; bit to; exp_t e;
    wait_result(lat, to);
    e = exp_q.pop_front();
    n_total++;
    if (to) begin
      $display("FAIL %s timeout: out_valid never rose", name);
      return;
    end else n_pass++;
    n_total++;
    if (out_data !== e.data) $display("FAIL %s data: got %h want %h", name, out_data, e.data);
    else n_pass++;
    n_total++;
    if (out_count !== e.count) $display("FAIL %s count: got %0d want %0d", name, out_count, e.count);
    else n_pass++;
    handshake();
  endtask

  task automatic test_reset();
    n_total++;
    if ({out_valid, in_ready, out_data, out_count} !== {1'b0, 1'b1, 16'h0, 16'h0})
      $display("FAIL reset_state: valid=%b ready=%b data=%h count=%0d want 0 1 0000 0",
               out_valid, in_ready, out_data, out_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; bit to; exp_t e;
    exp_q.push_back('{16'h02FD, 16'd3});
    send(8'hFF, 0, 0, 0);
    send(8'hFF, 0, 0, 0);
    send(8'hFF, 0, 1, 0);
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL b2b_ready_after_last: got %b want 0", in_ready);
    else n_pass++;
    wait_result(lat, to);
    n_total++;
    if (lat != 4) $display("FAIL b2b_latency: got %0d want 4", lat);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (out_data !== e.data) $display("FAIL b2b_data: got %h want %h", out_data, e.data);
    else n_pass++;
    n_total++;
    if (out_count !== e.count) $display("FAIL b2b_count: got %0d want %0d", out_count, e.count);
    else n_pass++;
    handshake();
  endtask

  task automatic test_subtract();
    exp_q.push_back('{16'h0007, 16'd2});
    send(8'd10, 0, 0, 0);
    send(8'd3, 1, 1, 0);
    take_result("sub_10_3");
    exp_q.push_back('{16'hFFF9, 16'd2});
    send(8'd3, 0, 0, 0);
    send(8'd10, 1, 1, 0);
    take_result("sub_3_10");
  endtask

  task automatic test_wrap();
    for (int n = 257; n <= 258; n++) begin
      logic [15:0] acc;
      acc = 16'(n * 255);
      exp_q.push_back('{acc, 16'(n)});
      for (int k = 0; k < n; k++) send(8'hFF, 0, k == n-1, 0);
      take_result(n == 257 ? "wrap_257" : "wrap_258");
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to; exp_t e; bit bad;
    exp_q.push_back('{16'h0046, 16'd2});
    send(8'h12, 0, 0, 0);
    send(8'h34, 0, 1, 0);
    wait_result(lat, to);
    e = exp_q.pop_front();
    n_total++;
    if (to) $display("FAIL bp_timeout: out_valid never rose");
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom_range(0, 255)); in_last = 1'b1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data || out_count !== e.count) begin
        bad = 1;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b data=%h count=%0d want 1 0 %h %0d",
                 k, out_valid, in_ready, out_data, out_count, e.data, e.count);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_total++;
    if (!bad) n_pass++;
    handshake();
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_after_handshake: ready=%b valid=%b want 1 0", in_ready, out_valid);
    else n_pass++;
    exp_q.push_back('{16'h0005, 16'd1});
    send(8'd5, 0, 1, 0);
    take_result("bp_next_frame");
  endtask

  task automatic test_clr();
    exp_q.push_back('{16'h0009, 16'd1});
    send(8'd5, 0, 0, 0);
    send(8'd7, 0, 0, 0);
    send(8'd9, 0, 1, 1);
    take_result("clr_with_last");
    // clr pulsed during RESOLVE must not disturb the result
    exp_q.push_back('{16'h0007, 16'd2});
    send(8'd3, 0, 0, 0);
    send(8'd4, 0, 1, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b0;
    take_result("clr_in_resolve");
    // idle clr in ACCUM discards the partial frame
    exp_q.push_back('{16'h0002, 16'd1});
    send(8'd6, 0, 0, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    send(8'd2, 0, 1, 0);
    take_result("clr_idle");
  endtask

  task automatic test_reset_mid();
    bit seen;
    send(8'd1, 0, 0, 0);
    send(8'd2, 0, 1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    n_total++;
    if (seen) $display("FAIL reset_mid_no_result: got out_valid=1 want 0");
    else n_pass++;
    exp_q.push_back('{16'h0041, 16'd2});
    send(8'h40, 0, 0, 0);
    send(8'h01, 0, 1, 0);
    take_result("post_reset_frame");
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      int n; logic [15:0] acc;
      n = $urandom_range(1, 6);
      acc = '0;
      for (int k = 0; k < n; k++) begin
        logic [7:0] d; bit sub;
        d = 8'($urandom_range(0, 255));
        sub = 1'($urandom_range(0, 1));
        acc = sub ? acc - 16'(d) : acc + 16'(d);
        send(d, sub, k == n-1, 0);
      end
      exp_q.push_back('{acc, 16'(n)});
      take_result("random");
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0;
    clr = 1'b0; out_ready = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    test_reset();
    rst = 1'b1;
    test_back_to_back();
    test_subtract();
    test_wrap();
    test_backpressure();
    test_clr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
